bin2bcd_param: RTL and testbench

Parametrised sequential binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm. It processes one input bit per clock. It is the generalised successor of the fixed 19-bit / 4-digit converter in the stop-watch display path: input width and digit count are parameters, results are held in a stable output register, and an overflow flag reports values that do not fit. It sits between the time/count datapath and the seven-segment / UART formatting logic.

---
 rtl/bin2bcd_param.sv | 130 +++++++++++++
 tb/tb_bin2bcd_param.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_param.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional macro BIN2BCD_SIGNED_EN: two's-complement input with a sign output.
module bin2bcd_param #(
   parameter int BIN_W  = 19,
   parameter int DIGITS = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  ready,
   output logic                  busy,
   output logic                  done_tick,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow
`ifdef BIN2BCD_SIGNED_EN
   ,
   output logic                  sign
`endif
);

   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int BCD_W = 4 * DIGITS;

   typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

   state_t             state, state_next;
   logic [BIN_W-1:0]   shift_reg;
   logic [BIN_W-1:0]   bin_mag;
   logic [BCD_W-1:0]   digits;
   logic [BCD_W-1:0]   digits_adj;
   logic [BCD_W-1:0]   digits_shift;
   logic [CNT_W-1:0]   cnt;
   logic               ovf_acc;
   logic               ovf_next;
   logic               last_shift;
`ifdef BIN2BCD_SIGNED_EN
   logic               bin_neg;
   logic               sign_acc;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   assign last_shift = (cnt == CNT_W'(1));

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = OP;
         OP:      if (last_shift) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Add-3 correction happens before the shift; the bit leaving the top digit feeds overflow.
   always_comb begin
      digits_adj = digits;
      for (int i = 0; i < DIGITS; i++) begin
         if (digits[4*i +: 4] > 4'd4) begin
            digits_adj[4*i +: 4] = digits[4*i +: 4] + 4'd3;
         end
      end
   end

   assign digits_shift = {digits_adj[BCD_W-2:0], shift_reg[BIN_W-1]};
   assign ovf_next     = ovf_acc | digits_adj[BCD_W-1];

`ifdef BIN2BCD_SIGNED_EN
   // Negating the most negative value wraps to itself, which is its correct unsigned magnitude.
   assign bin_neg = bin[BIN_W-1];
   assign bin_mag = bin_neg ? (~bin + BIN_W'(1)) : bin;
`else
   assign bin_mag = bin;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         shift_reg <= '0;
         digits    <= '0;
         cnt       <= '0;
         ovf_acc   <= 1'b0;
         bcd       <= '0;
         overflow  <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
         sign_acc  <= 1'b0;
         sign      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shift_reg <= bin_mag;
                  digits    <= '0;
                  ovf_acc   <= 1'b0;
                  cnt       <= CNT_W'(BIN_W);
`ifdef BIN2BCD_SIGNED_EN
                  sign_acc  <= bin_neg;
`endif
               end
            end
            OP: begin
               shift_reg <= {shift_reg[BIN_W-2:0], 1'b0};
               digits    <= digits_shift;
               ovf_acc   <= ovf_next;
               cnt       <= cnt - CNT_W'(1);
               if (last_shift) begin
                  bcd      <= digits_shift;
                  overflow <= ovf_next;
`ifdef BIN2BCD_SIGNED_EN
                  sign     <= sign_acc;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign ready     = (state == IDLE);
   assign busy      = (state == OP) || (state == DONE);
   assign done_tick = (state == DONE);

endmodule

// File: tb/tb_bin2bcd_param.sv
// Self-checking bench for bin2bcd_param: a 6-digit and a 4-digit instance, scoreboard plus directed checks.
module tb_bin2bcd_param;

   localparam int BIN_W = 19;

   typedef struct packed {
      logic [23:0] bcd;
      logic        ovf;
      logic        sgn;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start6 = 1'b0, start4 = 1'b0;
   logic [BIN_W-1:0]  bin6 = '0, bin4 = '0;
   logic              ready6, busy6, done6, ovf6;
   logic              ready4, busy4, done4, ovf4;
   logic [23:0]       bcd6;
   logic [15:0]       bcd4;
`ifdef BIN2BCD_SIGNED_EN
   logic              sign6, sign4;
`endif

   int checks = 0;
   int errors = 0;
   int done6Count = 0;
   exp_t q6[$];
   exp_t q4[$];

   always #5 clk = ~clk;

   bin2bcd_param #(.BIN_W(BIN_W), .DIGITS(6)) dut6 (
      .clk(clk), .reset(reset), .start(start6), .bin(bin6),
      .ready(ready6), .busy(busy6), .done_tick(done6), .bcd(bcd6), .overflow(ovf6)
`ifdef BIN2BCD_SIGNED_EN
      , .sign(sign6)
`endif
   );

   bin2bcd_param #(.BIN_W(BIN_W), .DIGITS(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .bin(bin4),
      .ready(ready4), .busy(busy4), .done_tick(done4), .bcd(bcd4), .overflow(ovf4)
`ifdef BIN2BCD_SIGNED_EN
      , .sign(sign4)
`endif
   );

   // Reference model: plain decimal division, independent of the shift-add-3 structure.
   function automatic exp_t model(input logic [BIN_W-1:0] b, input int nd);
      exp_t   e;
      longint v;
      e = '0;
      v = longint'(b);
`ifdef BIN2BCD_SIGNED_EN
      if (b[BIN_W-1]) begin
         v = (longint'(1) << BIN_W) - v;
         e.sgn = 1'b1;
      end
`endif
      for (int i = 0; i < nd; i++) begin
         e.bcd[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      e.ovf = (v != 0);
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Drives one start pulse on the selected instance and queues the expected result.
   task automatic applyStimulus(input bit sel4, input logic [BIN_W-1:0] v);
      if (sel4) begin
         checkOutput("ready4_before_start", 32'(ready4), 32'd1);
         bin4   = v;
         start4 = 1'b1;
         q4.push_back(model(v, 4));
      end else begin
         checkOutput("ready6_before_start", 32'(ready6), 32'd1);
         bin6   = v;
         start6 = 1'b1;
         q6.push_back(model(v, 6));
      end
      @(negedge clk);
      start4 = 1'b0;
      start6 = 1'b0;
   endtask

   // Called at the first negedge after the accepting edge (cycle 1); returns the done cycle.
   task automatic waitDone(input bit sel4, output int n);
      n = 1;
      while (!(sel4 ? done4 : done6) && n < 60) begin
         @(negedge clk);
         n++;
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!reset && done6) begin
         done6Count++;
         checkOutput("dut6_result_expected", 32'(q6.size() != 0), 32'd1);
         if (q6.size() != 0) begin
            e = q6.pop_front();
            checkOutput("dut6_bcd", 32'(bcd6), 32'(e.bcd));
            checkOutput("dut6_ovf", 32'(ovf6), 32'(e.ovf));
`ifdef BIN2BCD_SIGNED_EN
            checkOutput("dut6_sign", 32'(sign6), 32'(e.sgn));
`endif
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!reset && done4) begin
         checkOutput("dut4_result_expected", 32'(q4.size() != 0), 32'd1);
         if (q4.size() != 0) begin
            e = q4.pop_front();
            checkOutput("dut4_bcd", 32'(bcd4), 32'(e.bcd[15:0]));
            checkOutput("dut4_ovf", 32'(ovf4), 32'(e.ovf));
`ifdef BIN2BCD_SIGNED_EN
            checkOutput("dut4_sign", 32'(sign4), 32'(e.sgn));
`endif
         end
      end
   end

   initial begin
      int n;
      int m;
      int doneBefore;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      $display("[TB] reset state");
      checkOutput("rst_ready", 32'(ready6), 32'd1);
      checkOutput("rst_busy", 32'(busy6), 32'd0);
      checkOutput("rst_done", 32'(done6), 32'd0);
      checkOutput("rst_bcd", 32'(bcd6), 32'd0);
      checkOutput("rst_ovf", 32'(ovf6), 32'd0);
      checkOutput("rst_ready4", 32'(ready4), 32'd1);

      $display("[TB] zero operand latency");
      applyStimulus(1'b0, 19'd0);
      checkOutput("t1_busy_in_op", 32'(busy6), 32'd1);
      waitDone(1'b0, n);
      checkOutput("t1_done_cycle", 32'(n), 32'd20);
      checkOutput("t1_bcd", 32'(bcd6), 32'h000000);
      checkOutput("t1_ovf", 32'(ovf6), 32'd0);
      @(negedge clk);
      checkOutput("t1_done_one_cycle", 32'(done6), 32'd0);
      checkOutput("t1_ready_after", 32'(ready6), 32'd1);

      $display("[TB] full-scale then back-to-back");
      applyStimulus(1'b0, 19'h7FFFF);
      waitDone(1'b0, n);
      checkOutput("t2a_done_cycle", 32'(n), 32'd20);
`ifndef BIN2BCD_SIGNED_EN
      checkOutput("t2a_bcd", 32'(bcd6), 32'h524287);
      checkOutput("t2a_ovf", 32'(ovf6), 32'd0);
`endif
      @(negedge clk);
      applyStimulus(1'b0, 19'd359999);
      repeat (4) @(negedge clk);
`ifndef BIN2BCD_SIGNED_EN
      checkOutput("t2_hold_mid_op", 32'(bcd6), 32'h524287);
`else
      checkOutput("t2_hold_mid_op", 32'(bcd6), 32'h000001);
`endif
      waitDone(1'b0, n);
      checkOutput("t2b_done_cycle", 32'(n), 32'd16);
`ifndef BIN2BCD_SIGNED_EN
      checkOutput("t2b_bcd", 32'(bcd6), 32'h359999);
`endif
      @(negedge clk);

      $display("[TB] four-digit instance overflow");
      applyStimulus(1'b1, 19'd12345);
      waitDone(1'b1, n);
      checkOutput("t3a_done_cycle", 32'(n), 32'd20);
      checkOutput("t3a_bcd", 32'(bcd4), 32'h2345);
      checkOutput("t3a_ovf", 32'(ovf4), 32'd1);
      @(negedge clk);
      applyStimulus(1'b1, 19'd9999);
      waitDone(1'b1, n);
      checkOutput("t3b_bcd", 32'(bcd4), 32'h9999);
      checkOutput("t3b_ovf", 32'(ovf4), 32'd0);
      @(negedge clk);

      $display("[TB] start held high, bin changing mid-conversion");
      checkOutput("t4_ready", 32'(ready6), 32'd1);
      bin6   = 19'd1000;
      start6 = 1'b1;
      q6.push_back(model(19'd1000, 6));
      @(negedge clk);
      n = 1;
      while (!done6 && n < 60) begin
         if (n == 5) bin6 = 19'd4444;
         @(negedge clk);
         n++;
      end
      checkOutput("t4_first_done_cycle", 32'(n), 32'd20);
      bin6 = 19'd77777;
      q6.push_back(model(19'd77777, 6));
      m = 0;
      do begin
         if (m == 5) bin6 = 19'd123;
         @(negedge clk);
         m++;
      end while (!done6 && m < 60);
      checkOutput("t4_done_spacing", 32'(m), 32'd21);
      start6 = 1'b0;
      @(negedge clk);
      checkOutput("t4_single_tick", 32'(done6), 32'd0);

      $display("[TB] reset during conversion");
      applyStimulus(1'b0, 19'd4321);
      repeat (6) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      q6.delete();
      checkOutput("t5_ready", 32'(ready6), 32'd1);
      checkOutput("t5_busy", 32'(busy6), 32'd0);
      checkOutput("t5_bcd", 32'(bcd6), 32'd0);
      checkOutput("t5_ovf", 32'(ovf6), 32'd0);
      doneBefore = done6Count;
      repeat (30) @(negedge clk);
      checkOutput("t5_no_done_after_abort", 32'(done6Count), 32'(doneBefore));

`ifdef BIN2BCD_SIGNED_EN
      $display("[TB] signed operands");
      applyStimulus(1'b0, 19'h7FFFF);
      waitDone(1'b0, n);
      checkOutput("t6a_sign", 32'(sign6), 32'd1);
      checkOutput("t6a_bcd", 32'(bcd6), 32'h000001);
      @(negedge clk);
      applyStimulus(1'b0, 19'h40000);
      waitDone(1'b0, n);
      checkOutput("t6b_sign", 32'(sign6), 32'd1);
      checkOutput("t6b_bcd", 32'(bcd6), 32'h262144);
      @(negedge clk);
      applyStimulus(1'b0, 19'h3FFFF);
      waitDone(1'b0, n);
      checkOutput("t6c_sign", 32'(sign6), 32'd0);
      checkOutput("t6c_bcd", 32'(bcd6), 32'h262143);
      @(negedge clk);
`endif

      $display("[TB] random operands through the scoreboard");
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, 19'($urandom_range(0, 524287)));
         waitDone(1'b0, n);
         checkOutput("rnd6_done_cycle", 32'(n), 32'd20);
         @(negedge clk);
         applyStimulus(1'b1, 19'($urandom_range(0, 524287)));
         waitDone(1'b1, n);
         checkOutput("rnd4_done_cycle", 32'(n), 32'd20);
         @(negedge clk);
      end

      checkOutput("q6_drained", 32'(q6.size()), 32'd0);
      checkOutput("q4_drained", 32'(q4.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
